ifu_fetch: RTL and testbench

Instruction fetch unit for the single-cycle MIPS core. Holds the PC, fetches each instruction from instruction memory over a req/ack handshake, and presents it to the decode/execute datapath. Computes the next PC from the control unit's PC_sel and the ALU branch flag once the datapath retires the instruction. Sits directly upstream of the control decoder: its `instr` output feeds opcode/func decode.

---
 rtl/ifu_fetch_pkg.sv | 21 ++
 rtl/ifu_fetch_npc.sv | 35 +++
 rtl/ifu_fetch.sv | 107 ++++++++++
 tb/tb_ifu_fetch.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/ifu_fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ifu_fetch_pkg
// Brief    : Shared next-PC select encodings for the fetch unit and ctrl.
// Revision : 1.0 - initial release
// ============================================================================
package ifu_fetch_pkg;

  // Next-PC select encodings driven by the control unit on pc_sel
  localparam logic [1:0] NPC_PC4    = 2'b00;
  localparam logic [1:0] NPC_BRANCH = 2'b01;
  localparam logic [1:0] NPC_JUMP   = 2'b10;
  localparam logic [1:0] NPC_JR     = 2'b11;

  // Byte offset of a 16-bit branch immediate: sign-extend, then word-scale
  function automatic logic [31:0] br_offset(input logic [15:0] imm16);
    return {{14{imm16[15]}}, imm16, 2'b00};
  endfunction

endpackage
`default_nettype wire

// File: rtl/ifu_fetch_npc.sv
`default_nettype none
// ============================================================================
// Module   : ifu_fetch_npc
// Brief    : Combinational next-PC computation (seq / branch / jump / jr).
// Revision : 1.0 - initial release
// ============================================================================
module ifu_fetch_npc
  import ifu_fetch_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [25:0] instr_lo,   // instr[25:0]; upper opcode bits not needed
  input  logic [1:0]  pc_sel,
  input  logic        br_taken,
  input  logic [31:0] rs_data,
  output logic [31:0] next_pc
);

  logic [31:0] w_pc4;

  assign w_pc4 = pc + 32'd4;

  // Select the next PC; all adds wrap modulo 2^32
  always_comb begin
    next_pc = w_pc4;
    case (pc_sel)
      NPC_PC4:    next_pc = w_pc4;
      NPC_BRANCH: next_pc = br_taken ? (w_pc4 + br_offset(instr_lo[15:0])) : w_pc4;
      NPC_JUMP:   next_pc = {w_pc4[31:28], instr_lo, 2'b00};
      NPC_JR:     next_pc = rs_data;
      default:    next_pc = w_pc4;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/ifu_fetch.sv
`default_nettype none
// ============================================================================
// Module   : ifu_fetch
// Brief    : Instruction fetch unit - PC register, req/ack fetch from imem,
//            registered instruction handoff to decode, next-PC update on retire.
// Revision : 1.0 - initial release
// ============================================================================
module ifu_fetch
  import ifu_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        rstn,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic [1:0]  pc_sel,
  input  logic        br_taken,
  input  logic [31:0] rs_data,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        fetch_err
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_VALID = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_state_nx;
  logic [31:0] r_pc;
  logic [31:0] r_instr;
  logic        r_req;
  logic        r_valid;
  logic        r_err;
  logic [31:0] w_npc;
  logic        w_retire;
  logic        w_misalign;

  ifu_fetch_npc u_npc (
    .pc       (r_pc),
    .instr_lo (r_instr[25:0]),
    .pc_sel   (pc_sel),
    .br_taken (br_taken),
    .rs_data  (rs_data),
    .next_pc  (w_npc)
  );

  assign w_retire   = (r_state == S_VALID) && instr_ready;
  assign w_misalign = (w_npc[1:0] != 2'b00);

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= S_IDLE;
    else       r_state <= w_state_nx;
  end

  // Next-state logic; HALT is only left through reset
  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      S_IDLE:  w_state_nx = S_FETCH;
      S_FETCH: if (imem_ack) w_state_nx = S_VALID;
      S_VALID: if (instr_ready) w_state_nx = w_misalign ? S_HALT : S_FETCH;
      S_HALT:  w_state_nx = S_HALT;
      default: w_state_nx = S_IDLE;
    endcase
  end

  // Registered outputs: req/valid track the upcoming state, instr captured on ack,
  // pc advances on a clean retire, a misaligned target freezes pc and flags error
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_pc    <= RESET_PC;
      r_instr <= 32'd0;
      r_req   <= 1'b0;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_req   <= (w_state_nx == S_FETCH);
      r_valid <= (w_state_nx == S_VALID);
      if ((r_state == S_FETCH) && imem_ack) r_instr <= imem_rdata;
      if (w_retire) begin
        if (w_misalign) r_err <= 1'b1;
        else            r_pc  <= w_npc;
      end
    end
  end

  assign imem_req    = r_req;
  assign imem_addr   = r_pc;
  assign instr       = r_instr;
  assign instr_valid = r_valid;
  assign pc          = r_pc;
  assign pc_plus4    = r_pc + 32'd4;
  assign fetch_err   = r_err;

endmodule
`default_nettype wire

// File: tb/tb_ifu_fetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_ifu_fetch
// Brief    : Directed self-checking bench for ifu_fetch.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ifu_fetch;

  logic        clk;
  logic        rstn;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic [1:0]  pc_sel;
  logic        br_taken;
  logic [31:0] rs_data;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        fetch_err;

  int n_checks = 0;
  int n_fail   = 0;

  ifu_fetch #(.RESET_PC(32'h0000_3000)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .instr       (instr),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .pc_sel      (pc_sel),
    .br_taken    (br_taken),
    .rs_data     (rs_data),
    .pc          (pc),
    .pc_plus4    (pc_plus4),
    .fetch_err   (fetch_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, ".pc"},    pc,          32'h3000);
    check({tag, ".pc4"},   pc_plus4,    32'h3004);
    check({tag, ".addr"},  imem_addr,   32'h3000);
    check({tag, ".req"},   {31'd0, imem_req},    32'd0);
    check({tag, ".instr"}, instr,       32'd0);
    check({tag, ".valid"}, {31'd0, instr_valid}, 32'd0);
    check({tag, ".err"},   {31'd0, fetch_err},   32'd0);
  endtask

  // Entered at a negedge where the DUT should be in FETCH at exp_pc.
  // Returns at the negedge after retirement.
  task automatic do_instr(input logic [31:0] exp_pc, input logic [31:0] word,
                          input int ack_dly, input int rdy_dly,
                          input logic [1:0] sel, input logic br, input logic [31:0] rs);
    check("fetch.req",  {31'd0, imem_req}, 32'd1);
    check("fetch.addr", imem_addr, exp_pc);
    check("fetch.err",  {31'd0, fetch_err}, 32'd0);
    for (int i = 0; i < ack_dly; i++) begin
      // stray retire with a misaligned jr must be ignored outside VALID
      instr_ready = 1'b1; pc_sel = 2'b11; rs_data = 32'h0000_0002;
      @(negedge clk);
      check("wait.req",   {31'd0, imem_req}, 32'd1);
      check("wait.addr",  imem_addr, exp_pc);
      check("wait.valid", {31'd0, instr_valid}, 32'd0);
    end
    instr_ready = 1'b0;
    imem_ack = 1'b1; imem_rdata = word;
    @(negedge clk);
    imem_ack = 1'b0; imem_rdata = 32'hDEAD_BEEF;
    check("valid.v",     {31'd0, instr_valid}, 32'd1);
    check("valid.instr", instr, word);
    check("valid.pc",    pc, exp_pc);
    check("valid.pc4",   pc_plus4, exp_pc + 32'd4);
    check("valid.req",   {31'd0, imem_req}, 32'd0);
    for (int i = 0; i < rdy_dly; i++) begin
      // stray ack with different data must not disturb the held instruction
      imem_ack = 1'b1; imem_rdata = ~word;
      @(negedge clk);
      check("hold.v",     {31'd0, instr_valid}, 32'd1);
      check("hold.instr", instr, word);
      check("hold.req",   {31'd0, imem_req}, 32'd0);
    end
    imem_ack = 1'b0;
    instr_ready = 1'b1; pc_sel = sel; br_taken = br; rs_data = rs;
    @(negedge clk);
    instr_ready = 1'b0; pc_sel = 2'b10; br_taken = 1'b1; rs_data = 32'h0000_0001;
    check("retire.valid", {31'd0, instr_valid}, 32'd0);
  endtask

  initial begin
    rstn = 1'b0; imem_ack = 1'b0; imem_rdata = 32'd0; instr_ready = 1'b0;
    pc_sel = 2'b00; br_taken = 1'b0; rs_data = 32'd0;
    repeat (2) @(negedge clk);
    check_reset_vals("rst");
    rstn = 1'b1;
    @(negedge clk);

    // sequential run, zero-wait memory
    do_instr(32'h3000, 32'h2000_3000, 0, 0, 2'b00, 1'b0, 32'd0);
    do_instr(32'h3004, 32'h2000_3004, 0, 0, 2'b00, 1'b0, 32'd0);
    do_instr(32'h3008, 32'h2000_3008, 0, 0, 2'b00, 1'b0, 32'd0);
    do_instr(32'h300C, 32'h2000_300C, 0, 0, 2'b00, 1'b0, 32'd0);
    // beq taken, imm -4 -> 0x3004
    do_instr(32'h3010, 32'h1022_FFFC, 0, 0, 2'b01, 1'b1, 32'd0);
    do_instr(32'h3004, 32'h2000_3004, 0, 0, 2'b00, 1'b0, 32'd0);
    do_instr(32'h3008, 32'h2000_3008, 0, 0, 2'b00, 1'b0, 32'd0);
    do_instr(32'h300C, 32'h2000_300C, 0, 0, 2'b00, 1'b0, 32'd0);
    // beq not taken -> 0x3014
    do_instr(32'h3010, 32'h1022_FFFC, 0, 0, 2'b01, 1'b0, 32'd0);
    do_instr(32'h3014, 32'h2000_3014, 0, 0, 2'b00, 1'b0, 32'd0);
    do_instr(32'h3018, 32'h2000_3018, 0, 0, 2'b00, 1'b0, 32'd0);
    do_instr(32'h301C, 32'h2000_301C, 0, 0, 2'b00, 1'b0, 32'd0);
    // jal target 26'hC40 -> 0x3100
    do_instr(32'h3020, 32'h0C00_0C40, 0, 0, 2'b10, 1'b0, 32'd0);
    // jr aligned -> 0x3040
    do_instr(32'h3100, 32'h03E0_0008, 0, 0, 2'b11, 1'b0, 32'h3040);
    // slow memory and slow retire
    do_instr(32'h3040, 32'h2000_3040, 3, 2, 2'b00, 1'b0, 32'd0);
    // jr to top of address space, then sequential wrap to 0
    do_instr(32'h3044, 32'h03E0_0008, 0, 0, 2'b11, 1'b0, 32'hFFFF_FFFC);
    do_instr(32'hFFFF_FFFC, 32'h2000_FFFC, 0, 0, 2'b00, 1'b0, 32'd0);
    // misaligned jr -> HALT
    do_instr(32'h0000_0000, 32'h03E0_0008, 0, 0, 2'b11, 1'b0, 32'h3002);
    for (int i = 0; i < 3; i++) begin
      check("halt.err",   {31'd0, fetch_err}, 32'd1);
      check("halt.req",   {31'd0, imem_req}, 32'd0);
      check("halt.valid", {31'd0, instr_valid}, 32'd0);
      check("halt.pc",    pc, 32'h0000_0000);
      imem_ack = 1'b1; instr_ready = 1'b1;
      @(negedge clk);
    end
    imem_ack = 1'b0; instr_ready = 1'b0;

    // reset out of HALT, then reset again in the middle of a fetch
    rstn = 1'b0;
    @(negedge clk);
    check_reset_vals("rst2");
    rstn = 1'b1;
    @(negedge clk);
    check("mid.req", {31'd0, imem_req}, 32'd1);
    rstn = 1'b0; imem_ack = 1'b1; imem_rdata = 32'hBAD0_BAD0;
    #1;
    check("mid.async_req", {31'd0, imem_req}, 32'd0);
    @(negedge clk);
    check_reset_vals("rst3");
    imem_ack = 1'b0;
    rstn = 1'b1;
    @(negedge clk);
    do_instr(32'h3000, 32'h2000_3000, 0, 0, 2'b00, 1'b0, 32'd0);
    check("post.addr", imem_addr, 32'h3004);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
